// File: rtl/ysyx_25020037_lsu_if.sv
// rtl/ysyx_25020037_lsu_if.sv - LSU upstream, writeback and memory port bundle
interface ysyx_25020037_lsu_if;
    // upstream (EXU) handshake and operands
    logic        exu_valid;
    logic        lsu_ready;
    logic [63:0] eu_to_lu_bus;
    logic        inst_l;
    logic        inst_s;
    logic [2:0]  funct3;

    // downstream (WBU) handshake and result
    logic        lsu_valid;
    logic        wbu_ready;
    logic [32:0] lu_to_wb_bus;

    // memory request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    // memory response channel
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // LSU side: issues memory requests, consumes EXU transfers
    modport master (
        input  exu_valid, eu_to_lu_bus, inst_l, inst_s, funct3,
        output lsu_ready,
        output lsu_valid, lu_to_wb_bus,
        input  wbu_ready,
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err
    );

    // environment side: EXU, WBU and memory
    modport slave (
        output exu_valid, eu_to_lu_bus, inst_l, inst_s, funct3,
        input  lsu_ready,
        input  lsu_valid, lu_to_wb_bus,
        output wbu_ready,
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_25020037_lsu.sv
// rtl/ysyx_25020037_lsu.sv - load/store unit with single outstanding memory access
module ysyx_25020037_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_25020037_lsu_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_src2;
    logic                r_is_store;
    logic [2:0]          r_funct3;
    logic [32:0]         r_out;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_in_addr;
    logic [31:0]         w_in_src2;
    logic                w_in_mem;
    logic                w_in_fault;
    logic                w_in_done;

    logic [31:0]         w_rd_shift;
    logic [7:0]          w_lane_b;
    logic [15:0]         w_lane_h;
    logic [31:0]         w_load_data;
    logic [31:0]         w_wdata;
    logic [3:0]          w_wstrb;

    assign w_accept  = bus.exu_valid & (r_state == S_IDLE);
    assign w_in_addr = bus.eu_to_lu_bus[63:32];
    assign w_in_src2 = bus.eu_to_lu_bus[31:0];
    assign w_in_mem  = bus.inst_l | bus.inst_s;
    // non-memory ops and faults skip the memory and finish right away
    assign w_in_done = ~w_in_mem | w_in_fault;

    // decide at accept time whether the operation is illegal or misaligned
    always_comb begin
        w_in_fault = 1'b0;
        if (bus.inst_l & bus.inst_s) begin
            w_in_fault = 1'b1;
        end else if (bus.inst_l) begin
            case (bus.funct3)
                3'b011, 3'b110, 3'b111: w_in_fault = 1'b1;
                default:                w_in_fault = 1'b0;
            endcase
        end else if (bus.inst_s) begin
            w_in_fault = bus.funct3[2] | (bus.funct3[1:0] == 2'b11);
        end
        if (w_in_mem) begin
            if ((bus.funct3[1:0] == 2'b01) && w_in_addr[0])
                w_in_fault = 1'b1;
            if ((bus.funct3[1:0] == 2'b10) && (w_in_addr[1:0] != 2'b00))
                w_in_fault = 1'b1;
        end
    end

    // extract the addressed lane from the read word and extend it
    always_comb begin
        w_rd_shift = bus.rsp_rdata >> {r_addr[1:0], 3'b000};
        w_lane_b   = w_rd_shift[7:0];
        w_lane_h   = r_addr[1] ? bus.rsp_rdata[31:16] : bus.rsp_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_load_data = {24'd0, w_lane_b};
            3'b001:  w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
            3'b101:  w_load_data = {16'd0, w_lane_h};
            default: w_load_data = bus.rsp_rdata;
        endcase
    end

    // replicate store data across lanes so the strobe alone picks the bytes
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_wdata = {4{r_src2[7:0]}};
                w_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{r_src2[15:0]}};
                w_wstrb = 4'b0011 << {r_addr[1], 1'b0};
            end
            default: begin
                w_wdata = r_src2;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic; a response is only looked at while waiting in RSP
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)       w_next = w_in_done ? S_DONE : S_REQ;
            S_REQ:  if (bus.req_ready)  w_next = S_RSP;
            S_RSP:  if (bus.rsp_valid)  w_next = S_DONE;
            S_DONE: if (bus.wbu_ready)  w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // operand latch and result register, held unchanged through DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr     <= '0;
            r_src2     <= 32'd0;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_out      <= 33'd0;
        end else if (w_accept) begin
            r_addr     <= w_in_addr;
            r_src2     <= w_in_src2;
            r_is_store <= bus.inst_s;
            r_funct3   <= bus.funct3;
            if (!w_in_mem)
                r_out <= {1'b0, w_in_addr};
            else if (w_in_fault)
                r_out <= {1'b1, w_in_addr};
        end else if ((r_state == S_RSP) && bus.rsp_valid) begin
            if (bus.rsp_err)
                r_out <= {1'b1, r_addr};
            else if (r_is_store)
                r_out <= 33'd0;
            else
                r_out <= {1'b0, w_load_data};
        end
    end

    // outputs decoded from state; request fields only assert while in REQ
    always_comb begin
        bus.lsu_ready    = (r_state == S_IDLE);
        bus.lsu_valid    = (r_state == S_DONE);
        bus.lu_to_wb_bus = r_out;
        bus.req_valid    = (r_state == S_REQ);
        bus.req_wen      = (r_state == S_REQ) & r_is_store;
        bus.req_addr     = {r_addr[ADDR_W-1:2], 2'b00};
        bus.req_wdata    = w_wdata;
        bus.req_wstrb    = ((r_state == S_REQ) && r_is_store) ? w_wstrb : 4'b0000;
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// tb/tb_ysyx_25020037_lsu.sv - scoreboard bench for the load/store unit
module tb_ysyx_25020037_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25020037_lsu_if lif ();

    ysyx_25020037_lsu #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lif)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp;

    // faulting operations: {inst_l, inst_s, funct3, address}
    logic        f_l    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        f_s    [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f_f3   [8] = '{3'b010, 3'b000, 3'b011, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101};
    logic [31:0] f_addr [8] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004,
                                32'h8000_0008, 32'h8000_0003, 32'h8000_0002, 32'h8000_0001};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic l, input logic s, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] src2);
        lif.eu_to_lu_bus = {res, src2};
        lif.inst_l       = l;
        lif.inst_s       = s;
        lif.funct3       = f3;
        lif.exu_valid    = 1'b1;
        step();
        lif.exu_valid    = 1'b0;
        lif.inst_l       = 1'b0;
        lif.inst_s       = 1'b0;
        lif.funct3       = 3'b111;
        lif.eu_to_lu_bus = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic wait_sig(input bit on_out, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if ((on_out ? lif.lsu_valid : lif.req_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[off*8 +: 8];
        h = w[off[1]*16 +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [35:0] store_model(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [3:0] strb;
        strb = 4'b0000;
        case (f3[1:0])
            2'b00: begin strb[off] = 1'b1; return {strb, d[7:0], d[7:0], d[7:0], d[7:0]}; end
            2'b01: return {(off[1] ? 4'b1100 : 4'b0011), d[15:0], d[15:0]};
            default: return {4'b1111, d};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_checks++; if (lif.lsu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_lsu_ready got %b exp 1", lif.lsu_ready); end
        n_checks++; if (lif.lsu_valid !== 1'b0) begin n_errors++; $display("FAIL reset_lsu_valid got %b exp 0", lif.lsu_valid); end
        n_checks++; if (lif.req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid got %b exp 0", lif.req_valid); end
        n_checks++; if (lif.req_wen !== 1'b0) begin n_errors++; $display("FAIL reset_req_wen got %b exp 0", lif.req_wen); end
        n_checks++; if (lif.req_wstrb !== 4'b0) begin n_errors++; $display("FAIL reset_req_wstrb got %h exp 0", lif.req_wstrb); end
        n_checks++; if (lif.lu_to_wb_bus !== 33'd0) begin n_errors++; $display("FAIL reset_bus got %h exp 0", lif.lu_to_wb_bus); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu();
        exp_q.push_back({1'b0, 32'h1234_5678});
        issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
        n_checks++; if (lif.lsu_valid !== 1'b1) begin n_errors++; $display("FAIL alu_latency lsu_valid got %b exp 1", lif.lsu_valid); end
        n_checks++; if (lif.lsu_ready !== 1'b0) begin n_errors++; $display("FAIL alu_lsu_ready got %b exp 0", lif.lsu_ready); end
        exp = exp_q.pop_front();
        n_checks++; if (lif.lu_to_wb_bus !== exp) begin n_errors++; $display("FAIL alu_bus got %h exp %h", lif.lu_to_wb_bus, exp); end
        lif.wbu_ready = 1'b1;
        step();
        lif.wbu_ready = 1'b0;
        n_checks++; if (lif.lsu_valid !== 1'b0) begin n_errors++; $display("FAIL alu_release lsu_valid got %b exp 0", lif.lsu_valid); end
        n_checks++; if (lif.lsu_ready !== 1'b1) begin n_errors++; $display("FAIL alu_release lsu_ready got %b exp 1", lif.lsu_ready); end
    endtask

    task automatic test_lb();
        exp_q.push_back({1'b0, 32'hFFFF_FF80});
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0);
        n_checks++; if (lif.req_valid !== 1'b1) begin n_errors++; $display("FAIL lb_req_valid got %b exp 1", lif.req_valid); end
        n_checks++; if (lif.req_addr !== 32'h8000_0000) begin n_errors++; $display("FAIL lb_req_addr got %h exp 80000000", lif.req_addr); end
        n_checks++; if (lif.req_wstrb !== 4'b0000) begin n_errors++; $display("FAIL lb_req_wstrb got %h exp 0", lif.req_wstrb); end
        n_checks++; if (lif.req_wen !== 1'b0) begin n_errors++; $display("FAIL lb_req_wen got %b exp 0", lif.req_wen); end
        lif.req_ready = 1'b1;
        step();
        lif.req_ready = 1'b0;
        n_checks++; if (lif.req_valid !== 1'b0 || lif.lsu_valid !== 1'b0) begin n_errors++; $display("FAIL lb_rsp_wait req_valid %b lsu_valid %b exp 0 0", lif.req_valid, lif.lsu_valid); end
        lif.rsp_valid = 1'b1;
        lif.rsp_rdata = 32'h80FF_0000;
        step();
        lif.rsp_valid = 1'b0;
        n_checks++; if (lif.lsu_valid !== 1'b1) begin n_errors++; $display("FAIL lb_latency lsu_valid got %b exp 1", lif.lsu_valid); end
        exp = exp_q.pop_front();
        n_checks++; if (lif.lu_to_wb_bus !== exp) begin n_errors++; $display("FAIL lb_bus got %h exp %h", lif.lu_to_wb_bus, exp); end
        lif.wbu_ready = 1'b1;
        step();
        lif.wbu_ready = 1'b0;
    endtask

    task automatic test_sh();
        exp_q.push_back(33'd0);
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hABCD_1234);
        n_checks++; if (lif.req_wen !== 1'b1) begin n_errors++; $display("FAIL sh_req_wen got %b exp 1", lif.req_wen); end
        n_checks++; if (lif.req_addr !== 32'h8000_0000) begin n_errors++; $display("FAIL sh_req_addr got %h exp 80000000", lif.req_addr); end
        n_checks++; if (lif.req_wdata !== 32'h1234_1234) begin n_errors++; $display("FAIL sh_req_wdata got %h exp 12341234", lif.req_wdata); end
        n_checks++; if (lif.req_wstrb !== 4'b1100) begin n_errors++; $display("FAIL sh_req_wstrb got %b exp 1100", lif.req_wstrb); end
        lif.req_ready = 1'b1;
        step();
        lif.req_ready = 1'b0;
        lif.rsp_valid = 1'b1;
        lif.rsp_rdata = 32'h5A5A_5A5A;
        step();
        lif.rsp_valid = 1'b0;
        exp = exp_q.pop_front();
        n_checks++; if (lif.lsu_valid !== 1'b1 || lif.lu_to_wb_bus !== exp) begin n_errors++; $display("FAIL sh_done valid %b bus %h exp 1 %h", lif.lsu_valid, lif.lu_to_wb_bus, exp); end
        lif.wbu_ready = 1'b1;
        step();
        lif.wbu_ready = 1'b0;
    endtask

    task automatic test_faults();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b1, f_addr[i]});
            issue(f_l[i], f_s[i], f_f3[i], f_addr[i], 32'h1111_2222);
            n_checks++; if (lif.req_valid !== 1'b0) begin n_errors++; $display("FAIL fault%0d_req_valid got %b exp 0", i, lif.req_valid); end
            n_checks++; if (lif.lsu_valid !== 1'b1) begin n_errors++; $display("FAIL fault%0d_latency lsu_valid got %b exp 1", i, lif.lsu_valid); end
            exp = exp_q.pop_front();
            n_checks++; if (lif.lu_to_wb_bus !== exp) begin n_errors++; $display("FAIL fault%0d_bus got %h exp %h", i, lif.lu_to_wb_bus, exp); end
            lif.wbu_ready = 1'b1;
            step();
            lif.wbu_ready = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        logic        s_wen;
        exp_q.push_back({1'b0, 32'hFFFF_8001});
        issue(1'b1, 1'b0, 3'b001, 32'h8000_0006, 32'h5555_AAAA);
        s_addr  = lif.req_addr;
        s_wdata = lif.req_wdata;
        s_wstrb = lif.req_wstrb;
        s_wen   = lif.req_wen;
        n_checks++; if (s_addr !== 32'h8000_0004) begin n_errors++; $display("FAIL stall_req_addr got %h exp 80000004", s_addr); end
        for (int i = 0; i < 5; i++) begin
            lif.rsp_valid = (i == 2);
            lif.rsp_rdata = 32'h0BAD_0BAD;
            n_checks++;
            if (lif.req_valid !== 1'b1 || lif.req_addr !== s_addr || lif.req_wdata !== s_wdata ||
                lif.req_wstrb !== s_wstrb || lif.req_wen !== s_wen || lif.lsu_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_req_hold%0d valid %b addr %h wdata %h wstrb %h wen %b ready %b exp 1 %h %h %h %b 0",
                         i, lif.req_valid, lif.req_addr, lif.req_wdata, lif.req_wstrb, lif.req_wen, lif.lsu_ready,
                         s_addr, s_wdata, s_wstrb, s_wen);
            end
            step();
        end
        lif.req_ready = 1'b1;
        lif.rsp_valid = 1'b1;
        step();
        lif.req_ready = 1'b0;
        lif.rsp_valid = 1'b0;
        n_checks++; if (lif.lsu_valid !== 1'b0 || lif.req_valid !== 1'b0) begin n_errors++; $display("FAIL stall_same_cycle_rsp lsu_valid %b req_valid %b exp 0 0", lif.lsu_valid, lif.req_valid); end
        step();
        n_checks++; if (lif.lsu_valid !== 1'b0) begin n_errors++; $display("FAIL stall_rsp_wait lsu_valid got %b exp 0", lif.lsu_valid); end
        lif.rsp_valid = 1'b1;
        lif.rsp_rdata = 32'h8001_1234;
        step();
        lif.rsp_valid = 1'b0;
        exp = exp_q.pop_front();
        lif.eu_to_lu_bus = {32'h0000_0042, 32'h0};
        lif.exu_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lif.lsu_valid !== 1'b1 || lif.lu_to_wb_bus !== exp || lif.lsu_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_out_hold%0d valid %b bus %h ready %b exp 1 %h 0", i, lif.lsu_valid, lif.lu_to_wb_bus, lif.lsu_ready, exp);
            end
            step();
        end
        lif.exu_valid = 1'b0;
        lif.wbu_ready = 1'b1;
        step();
        lif.wbu_ready = 1'b0;
        n_checks++; if (lif.lsu_valid !== 1'b0 || lif.lsu_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release valid %b ready %b exp 0 1", lif.lsu_valid, lif.lsu_ready); end
        step();
        n_checks++; if (lif.lsu_valid !== 1'b0) begin n_errors++; $display("FAIL stall_no_phantom lsu_valid got %b exp 0", lif.lsu_valid); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
        lif.req_ready = 1'b1;
        step();
        lif.req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++; if (lif.lsu_ready !== 1'b1 || lif.lsu_valid !== 1'b0 || lif.req_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_state ready %b valid %b req %b exp 1 0 0", lif.lsu_ready, lif.lsu_valid, lif.req_valid); end
        lif.rsp_valid = 1'b1;
        lif.rsp_rdata = 32'hCAFE_F00D;
        step();
        lif.rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lif.lsu_valid !== 1'b0 || lif.lsu_ready !== 1'b1 || lif.lu_to_wb_bus !== 33'd0) begin
                n_errors++;
                $display("FAIL midrst_late_rsp%0d valid %b ready %b bus %h exp 0 1 0", i, lif.lsu_valid, lif.lsu_ready, lif.lu_to_wb_bus);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int          kind;
        logic [2:0]  f3;
        logic [31:0] res, src2, rdata;
        logic        err;
        logic [35:0] st;
        bit          ok;
        for (int n = 0; n < 24; n++) begin
            kind  = $urandom_range(0, 2);
            res   = $urandom;
            src2  = $urandom;
            rdata = $urandom;
            f3    = (kind == 0) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            if (f3[1:0] == 2'b01) res[0] = 1'b0;
            if (f3[1:0] == 2'b10) res[1:0] = 2'b00;
            err = (kind != 2) && ($urandom_range(0, 4) == 0);
            if (kind == 2)      exp = {1'b0, res};
            else if (err)       exp = {1'b1, res};
            else if (kind == 1) exp = 33'd0;
            else                exp = {1'b0, load_model(f3, res[1:0], rdata)};
            exp_q.push_back(exp);
            st = store_model(f3, res[1:0], src2);
            issue(kind == 0, kind == 1, f3, res, src2);
            if (kind != 2) begin
                wait_sig(1'b0, ok);
                n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b%0d_req_timeout got 0 exp 1", n); end
                n_checks++; if (lif.req_wen !== (kind == 1) || lif.req_addr !== {res[31:2], 2'b00}) begin n_errors++; $display("FAIL b2b%0d_req wen %b addr %h exp %b %h", n, lif.req_wen, lif.req_addr, kind == 1, {res[31:2], 2'b00}); end
                n_checks++;
                if ((kind == 1) ? (lif.req_wstrb !== st[35:32] || lif.req_wdata !== st[31:0]) : (lif.req_wstrb !== 4'b0)) begin
                    n_errors++;
                    $display("FAIL b2b%0d_wdata strb %h wdata %h exp %h %h", n, lif.req_wstrb, lif.req_wdata, (kind == 1) ? st[35:32] : 4'h0, st[31:0]);
                end
                repeat ($urandom_range(0, 2)) step();
                lif.req_ready = 1'b1;
                step();
                lif.req_ready = 1'b0;
                repeat ($urandom_range(0, 2)) step();
                lif.rsp_valid = 1'b1;
                lif.rsp_rdata = rdata;
                lif.rsp_err   = err;
                step();
                lif.rsp_valid = 1'b0;
                lif.rsp_err   = 1'b0;
            end
            wait_sig(1'b1, ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b%0d_out_timeout got 0 exp 1", n); end
            repeat ($urandom_range(0, 2)) step();
            exp = exp_q.pop_front();
            n_checks++; if (lif.lsu_valid !== 1'b1 || lif.lu_to_wb_bus !== exp) begin n_errors++; $display("FAIL b2b%0d_bus valid %b got %h exp %h", n, lif.lsu_valid, lif.lu_to_wb_bus, exp); end
            lif.wbu_ready = 1'b1;
            step();
            lif.wbu_ready = 1'b0;
        end
    endtask

    initial begin
        rst              = 1'b0;
        lif.exu_valid    = 1'b0;
        lif.eu_to_lu_bus = 64'd0;
        lif.inst_l       = 1'b0;
        lif.inst_s       = 1'b0;
        lif.funct3       = 3'd0;
        lif.wbu_ready    = 1'b0;
        lif.req_ready    = 1'b0;
        lif.rsp_valid    = 1'b0;
        lif.rsp_rdata    = 32'd0;
        lif.rsp_err      = 1'b0;
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_faults();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_25020037_lsu.md
YSYX_25020037_LSU -- requirements
Module: ysyx_25020037_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the memory address width in bits (only 32 is supported).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-low
- exu_valid  in  1  upstream EXU has a valid transfer
- lsu_ready  out  1  LSU can accept a transfer
- eu_to_lu_bus  in  64  {result[31:0], src2[31:0]}; result = address or ALU value, src2 = store data
- inst_l  in  1  operation is a load
- inst_s  in  1  operation is a store
- funct3  in  3  access size/sign (RV32I encoding)
- lsu_valid  out  1  output bus holds a valid transfer
- wbu_ready  in  1  downstream WBU accepts
- lu_to_wb_bus  out  33  {fault, data[31:0]}
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_wen  out  1  1 = write, 0 = read
- req_addr  out  32  word-aligned byte address ({addr[31:2], 2'b00})
- req_wdata  out  32  lane-replicated store data
- req_wstrb  out  4  byte enables (0 for reads)
- rsp_valid  in  1  memory response valid (one-cycle pulse)
- rsp_rdata  in  32  read word
- rsp_err  in  1  access error

Function
REQ-003 SHALL implement states IDLE, REQ, RSP, DONE; lsu_ready = (state == IDLE).
REQ-004 SHALL accept when exu_valid & lsu_ready, latching eu_to_lu_bus, inst_l, inst_s and funct3 that cycle; inputs are ignored outside IDLE.
REQ-005 From IDLE on accept, SHALL go to DONE if neither inst_l nor inst_s is set, with data = result and fault = 0.
REQ-006 From IDLE on accept, SHALL go to DONE with fault = 1, data = addr, and no memory request if any of these hold: inst_l & inst_s; funct3 illegal (load: 011/110/111; store: anything other than 000/001/010); halfword with addr[0] = 1; word with addr[1:0] != 0.
REQ-007 Otherwise SHALL go to REQ; req_valid = 1 only in REQ, with req_* held stable until req_ready.
REQ-008 In REQ, SHALL move to RSP on req_valid & req_ready.
REQ-009 In RSP, SHALL move to DONE on rsp_valid; a rsp_valid in the same cycle as the req_ready handshake is not accepted.
REQ-010 Store data encoding:
- SB: wdata = {4{src2[7:0]}}, wstrb = 4'b0001 << addr[1:0]
- SH: wdata = {2{src2[15:0]}}, wstrb = 4'b0011 << {addr[1],1'b0}
- SW: wdata = src2, wstrb = 4'b1111
REQ-011 Load data SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-012 Store completion SHALL give data = 0, fault = 0.
REQ-013 On rsp_err = 1 with rsp_valid, SHALL give fault = 1, data = addr.
REQ-014 In DONE, lsu_valid = 1 and lu_to_wb_bus SHALL be held stable until wbu_ready; then state goes to IDLE with lsu_valid = 0 the next cycle (no same-cycle re-accept).
REQ-015 Latency: a non-memory or faulting op SHALL assert lsu_valid 1 cycle after accept. A zero-wait load/store (req_ready = 1, rsp_valid the cycle after the handshake) SHALL assert lsu_valid 3 cycles after accept.
REQ-016 rsp_valid outside RSP SHALL be ignored.

Reset
REQ-017 While rst = 0 at posedge clk, SHALL set state = IDLE, lsu_ready = 1, lsu_valid = 0, req_valid = 0, req_wen = 0, req_wstrb = 0, and lu_to_wb_bus = 0.
REQ-018 Reset mid-transaction SHALL abandon the operation; a late rsp_valid after reset SHALL be ignored per REQ-016.

Verification
REQ-019 The bench SHALL cover:
- ALU pass-through: result = 0x1234_5678, no l/s -> one cycle later lsu_valid = 1, bus = {0, 0x12345678}.
- LB addr 0x8000_0003, rsp_rdata = 0x80FF_0000 -> req_addr 0x8000_0000, wstrb 0, data = 0xFFFF_FF80.
- SH addr 0x8000_0002, src2 = 0xABCD_1234 -> wdata 0x1234_1234, wstrb 4'b1100, data 0.
- LW addr 0x8000_0001 -> no req_valid, fault = 1, data = 0x8000_0001.
- req_ready held low 5 cycles, then wbu_ready low 3 cycles -> req_* and output bus stable throughout; lsu_ready = 0 until return to IDLE.
- rst = 0 asserted in RSP, then rsp_valid pulse -> IDLE, lsu_valid stays 0.
